point_add: RTL and testbench

Affine elliptic-curve point adder over the BLS12-377 base field (377-bit prime p). It computes R = P + Q for two affine points with distinct x-coordinates, using a sequential datapath: one modular adder/subtractor, one bit-serial modular multiplier and one binary-extended-Euclid inverter. It is the group-add primitive used by the MSM bucket-accumulation logic and runs one addition per reset.

---
 rtl/point_add.sv | 209 ++++++++++++++++++++
 tb/tb_point_add.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/point_add.sv
// Affine point adder R = P + Q over the BLS12-377 base field, one addition per reset.
// Sequential datapath: modular add/sub, MSB-first serial multiplier, binary Euclid inverter.

package point_add_pkg;
    localparam int P_WIDTH = 377;
    localparam logic [383:0] MODULUS_HEX =
        384'h01ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001;
    localparam logic [P_WIDTH-1:0] MODULUS = MODULUS_HEX[P_WIDTH-1:0];
    typedef logic [P_WIDTH-1:0] fe_t;
endpackage

module point_add
    import point_add_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*P_WIDTH-1:0] p,
    input  logic [2*P_WIDTH-1:0] q,
    output logic [2*P_WIDTH-1:0] r,
    output logic                 done
);
    typedef enum logic [3:0] {
        LOAD, SUB1, CHK, INV, MUL_L, SQR, SUB2, SUB3, MUL3, SUB4, DONE
    } state_t;

    typedef logic [P_WIDTH:0] wide_t;
    localparam int    CNT_W    = $clog2(P_WIDTH);
    localparam wide_t MOD_W    = {1'b0, MODULUS};
    localparam fe_t   ONE      = fe_t'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(P_WIDTH - 1);

    function automatic fe_t mod_add(input fe_t a, input fe_t b);
        wide_t s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= MOD_W) s = s - MOD_W;
        return s[P_WIDTH-1:0];
    endfunction

    function automatic fe_t mod_sub(input fe_t a, input fe_t b);
        wide_t d;
        d = {1'b0, a} - {1'b0, b};
        if (d[P_WIDTH]) d = d + MOD_W;
        return d[P_WIDTH-1:0];
    endfunction

    // (x / 2) mod p: an odd x is made even by adding p; the extra bit keeps the sum exact.
    function automatic fe_t mod_half(input fe_t x);
        wide_t s;
        s = x[0] ? ({1'b0, x} + MOD_W) : {1'b0, x};
        return s[P_WIDTH:1];
    endfunction

    state_t           state;
    fe_t              px, py, qx, qy;
    fe_t              num, den;
    fe_t              iu, iv, x1, x2;
    fe_t              mul_a, mul_b, acc;
    fe_t              lam, tmp, rx, ry;
    logic [CNT_W-1:0] cnt;
    logic             sub_phase;

    fe_t mul_next;
    fe_t iu_next, iv_next, x1_next, x2_next;

    // One multiplier step: acc = 2*acc + (next bit of b ? a : 0), reduced each time.
    always_comb begin
        mul_next = mod_add(acc, acc);
        if (mul_b[P_WIDTH-1]) mul_next = mod_add(mul_next, mul_a);
    end

    // Inverter step keeps x1*den == iu and x2*den == iv (mod p); odd-odd cases subtract and halve together.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
        iu_next = iu;
        iv_next = iv;
        x1_next = x1;
        x2_next = x2;
        if (!iu[0]) begin
            iu_next = iu >> 1;
            x1_next = mod_half(x1);
        end else if (!iv[0]) begin
            iv_next = iv >> 1;
            x2_next = mod_half(x2);
        end else if (iu >= iv) begin
            iu_next = (iu - iv) >> 1;
            x1_next = mod_half(mod_sub(x1, x2));
        end else begin
            iv_next = (iv - iu) >> 1;
            x2_next = mod_half(mod_sub(x2, x1));
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            px        <= '0;
            py        <= '0;
            qx        <= '0;
            qy        <= '0;
            num       <= '0;
            den       <= '0;
            iu        <= '0;
            iv        <= '0;
            x1        <= '0;
            x2        <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            acc       <= '0;
            lam       <= '0;
            tmp       <= '0;
            rx        <= '0;
            ry        <= '0;
            cnt       <= '0;
            sub_phase <= 1'b0;
            r         <= '0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    px    <= p[2*P_WIDTH-1:P_WIDTH];
                    py    <= p[P_WIDTH-1:0];
                    qx    <= q[2*P_WIDTH-1:P_WIDTH];
                    qy    <= q[P_WIDTH-1:0];
                    state <= SUB1;
                end
                SUB1: begin
                    num   <= mod_sub(qy, py);
                    den   <= mod_sub(qx, px);
                    state <= CHK;
                end
                CHK: begin
                    if (den == '0) begin
                        rx    <= '0;
                        ry    <= '0;
                        state <= DONE;
                    end else begin
                        iu    <= den;
                        iv    <= MODULUS;
                        x1    <= ONE;
                        x2    <= '0;
                        state <= INV;
                    end
                end
                INV: begin
                    if (iu == ONE || iv == ONE) begin
                        mul_a <= num;
                        mul_b <= (iu == ONE) ? x1 : x2;
                        acc   <= '0;
                        cnt   <= CNT_INIT;
                        state <= MUL_L;
                    end else begin
                        iu <= iu_next;
                        iv <= iv_next;
                        x1 <= x1_next;
                        x2 <= x2_next;
                    end
                end
                MUL_L, SQR, MUL3: begin
                    acc   <= mul_next;
                    mul_b <= mul_b << 1;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        acc <= '0;
                        cnt <= CNT_INIT;
                        if (state == MUL_L) begin
                            lam   <= mul_next;
                            mul_a <= mul_next;
                            mul_b <= mul_next;
                            state <= SQR;
                        end else if (state == SQR) begin
                            tmp   <= mul_next;
                            state <= SUB2;
                        end else begin
                            tmp   <= mul_next;
                            state <= SUB4;
                        end
                    end
                end
                SUB2: begin
                    if (!sub_phase) begin
                        tmp       <= mod_sub(tmp, px);
                        sub_phase <= 1'b1;
                    end else begin
                        rx    <= mod_sub(tmp, qx);
                        state <= SUB3;
                    end
                end
                SUB3: begin
                    mul_a <= lam;
                    mul_b <= mod_sub(px, rx);
                    acc   <= '0;
                    cnt   <= CNT_INIT;
                    state <= MUL3;
                end
                SUB4: begin
                    ry    <= mod_sub(tmp, py);
                    state <= DONE;
                end
                DONE: begin
                    r    <= {rx, ry};
                    done <= 1'b1;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_point_add.sv
// Self-checking bench for point_add: a Fermat-inverse field model drives a per-cycle
// compare process, and directed vectors pin both the model and the DUT.

module tb_point_add;
    import point_add_pkg::*;

    localparam int W = P_WIDTH;
    typedef logic [2*W-1:0] pt_t;
    typedef logic [2*W-1:0] dbl_t;

    localparam logic [383:0] PX_H = 384'h116a2c0f839d9608121202ed49d41a2fb23252aa7ae75c60ad61d9cf807e53ff10ba3ff99bf43ff6c8bfbbc6528a33b;
    localparam logic [383:0] PY_H = 384'h10bd644104333b1a8dbdf058a5136c194b1ff7e9731969156a8c4dfd46446cd5d93a2de3130da01999d9072585ff593;
    localparam logic [383:0] QX_H = 384'h15cb2b78125751fb25b7414331049db03171d64163d3e4d7f24d1b49a7dec64b7556430086a8cd5cf7e0538b54e5aae;
    localparam logic [383:0] QY_H = 384'hda2ff1d86d14ac58e419e9dc65ffdabf150a885dad5e7a9fb67241f54eb899f963e749d0cc3eee2281231e05461396;
    localparam logic [383:0] RX_H = 384'h11d0606bfe4dd39c34390e3a47c4ac9b9d8c7fb0d91e4bc74f45331e7906339d051cca0bd781fcaa198e1e946e08e8f;
    localparam logic [383:0] RY_H = 384'h214efdc19577de50b18ee9cadd843e9d055e706485fe221a382d4a02c48b2ddc8de32394077dbf860cd38e63cf135d;

    localparam pt_t MAIN_P = {PX_H[W-1:0], PY_H[W-1:0]};
    localparam pt_t MAIN_Q = {QX_H[W-1:0], QY_H[W-1:0]};
    localparam pt_t MAIN_R = {RX_H[W-1:0], RY_H[W-1:0]};
    localparam pt_t WRAP_P = '0;
    localparam pt_t WRAP_Q = {fe_t'(1), fe_t'(2)};
    localparam pt_t WRAP_R = {fe_t'(3), MODULUS - fe_t'(6)};
    localparam pt_t DEG_P  = {fe_t'(5), fe_t'(7)};
    localparam pt_t DEG_Q  = {fe_t'(5), fe_t'(9)};
    localparam dbl_t MOD_D = dbl_t'(MODULUS);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    pt_t  p, q, r;
    logic done;

    point_add dut (
        .clk  (clk),
        .rst_n(rst_n),
        .p    (p),
        .q    (q),
        .r    (r),
        .done (done)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic mon_en   = 1'b0;
    pt_t  exp_r    = '0;

    task automatic check(input string name, input dbl_t actual, input dbl_t expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, actual, expected);
    endtask

    // Field model using plain wide arithmetic and % p.
    function automatic fe_t f_mul(input fe_t a, input fe_t b);
        dbl_t prod;
        prod = dbl_t'(a) * dbl_t'(b);
        return fe_t'(prod % MOD_D);
    endfunction

    function automatic fe_t f_sub(input fe_t a, input fe_t b);
        dbl_t d;
        d = (dbl_t'(a) + MOD_D - dbl_t'(b)) % MOD_D;
        return fe_t'(d);
    endfunction

    // Inverse as a^(p-2) by square-and-multiply.
    function automatic fe_t f_inv(input fe_t a);
        fe_t e;
        fe_t res;
        e   = MODULUS - fe_t'(2);
        res = fe_t'(1);
        for (int i = W - 1; i >= 0; i--) begin
            res = f_mul(res, res);
            if (e[i]) res = f_mul(res, a);
        end
        return res;
    endfunction

    function automatic pt_t model_add(input pt_t pp, input pt_t qq);
        fe_t ax, ay, bx, by, lam, cx, cy;
        ax = pp[2*W-1:W];
        ay = pp[W-1:0];
        bx = qq[2*W-1:W];
        by = qq[W-1:0];
        if (ax == bx) return '0;
        lam = f_mul(f_sub(by, ay), f_inv(f_sub(bx, ax)));
        cx  = f_sub(f_sub(f_mul(lam, lam), ax), bx);
        cy  = f_sub(f_mul(lam, f_sub(ax, cx)), ay);
        return {cx, cy};
    endfunction

    // Per-cycle compare: zeros under reset and while busy, the model result once done.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                check("reset_r", r, '0);
                check("reset_done", dbl_t'(done), '0);
            end else if (done) begin
                check("r_vs_model", r, exp_r);
            end else begin
                check("r_hidden_while_busy", r, '0);
            end
        end
    end

    // Reset, present operands, release; returns just after the LOAD edge with inputs scrambled.
    task automatic start_op(input pt_t pp, input pt_t qq);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        p     = pp;
        q     = qq;
        exp_r = model_add(pp, qq);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p = ~pp;
        q = ~qq;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        p = '0;
        q = '0;

        check("model_main", model_add(MAIN_P, MAIN_Q), MAIN_R);
        check("model_swap", model_add(MAIN_Q, MAIN_P), MAIN_R);
        check("model_wrap", model_add(WRAP_P, WRAP_Q), WRAP_R);
        check("model_degen", model_add(DEG_P, DEG_Q), '0);

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        #2;
        check("reset_state_r", r, '0);
        check("reset_state_done", dbl_t'(done), '0);

        start_op(MAIN_P, MAIN_Q);
        wait_done(2000, cyc);
        check("main_done_within_2000", dbl_t'(done), 1);
        check("main_r", r, MAIN_R);

        p = MAIN_Q;
        q = WRAP_Q;
        repeat (100) @(negedge clk);
        check("hold_done", dbl_t'(done), 1);
        check("hold_r", r, MAIN_R);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_clear_r", r, '0);
        check("async_clear_done", dbl_t'(done), '0);

        start_op(MAIN_Q, MAIN_P);
        wait_done(2000, cyc);
        check("swap_done", dbl_t'(done), 1);
        check("swap_r", r, MAIN_R);

        start_op(WRAP_P, WRAP_Q);
        wait_done(2000, cyc);
        check("wrap_done", dbl_t'(done), 1);
        check("wrap_r", r, WRAP_R);

        start_op(DEG_P, DEG_Q);
        wait_done(10, cyc);
        check("degen_latency", dbl_t'(cyc), 3);
        check("degen_done", dbl_t'(done), 1);
        check("degen_r", r, '0);

        start_op(MAIN_P, MAIN_Q);
        repeat (500) @(posedge clk);
        #3;
        check("midop_busy", dbl_t'(done), '0);
        rst_n = 1'b0;
        #1;
        check("midop_reset_r", r, '0);
        check("midop_reset_done", dbl_t'(done), '0);
        p     = WRAP_P;
        q     = WRAP_Q;
        exp_r = model_add(WRAP_P, WRAP_Q);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wait_done(2000, cyc);
        check("midop_final_done", dbl_t'(done), 1);
        check("midop_final_r", r, WRAP_R);

        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
